// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM state codes.
// Imported by the lane aligner and the top-level controller.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef logic [1:0] lsu_state_t;

   localparam lsu_state_t IDLE = 2'b00;
   localparam lsu_state_t RD   = 2'b01;
   localparam lsu_state_t WR   = 2'b10;
   localparam lsu_state_t RESP = 2'b11;

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side request/response handshake of the load/store unit.
// The slave modport is the unit itself; the master modport is the pipeline.
interface lsu_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_write_i;
   logic [1:0]        req_size_i;
   logic              req_signed_i;
   logic [ADDR_W-1:0] req_addr_i;
   logic [31:0]       req_wdata_i;
   logic              resp_valid_o;
   logic              resp_ready_i;
   logic [31:0]       resp_rdata_o;
   logic              resp_err_o;

   modport master (
      output req_valid_i, req_write_i, req_size_i, req_signed_i,
             req_addr_i, req_wdata_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );

   modport slave (
      input  req_valid_i, req_write_i, req_size_i, req_signed_i,
             req_addr_i, req_wdata_i, resp_ready_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: extracts and extends load data from a word,
// and merges sub-word store data into a word for read-modify-write.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] store_word
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign byte_lane = word[{addr_lo, 3'b000} +: 8];
   assign half_lane = word[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      load_val = 32'h0;
      case (size)
         SZ_BYTE: load_val = {{24{sgn & byte_lane[7]}}, byte_lane};
         SZ_HALF: load_val = {{16{sgn & half_lane[15]}}, half_lane};
         SZ_WORD: load_val = word;
         default: load_val = 32'h0;
      endcase
   end

   // Only the addressed lane is replaced; the other lanes keep the read word.
   always_comb begin
      store_word = word;
      case (size)
         SZ_BYTE: store_word[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
         SZ_HALF: store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         SZ_WORD: store_word = wdata;
         default: store_word = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage access controller in front of the data memory: word/half/byte
// loads and stores, sub-word stores as read-modify-write, early error reject.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = 32,
   parameter int ADDR_W    = 32
)(
   input  logic              clk_i,
   input  logic              rst_i,
   lsu_if.slave              bus,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              mem_write_o,
   output logic              mem_read_o,
   input  logic [31:0]       mem_rdata_i
);

   lsu_state_t        state_q;
   logic              write_q;
   logic              sgn_q;
   logic              err_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       word_q;
   logic [31:0]       rdata_q;

   logic              accept;
   logic              req_err;
   logic [ADDR_W-1:0] req_aligned;
   logic [31:0]       load_val;
   logic [31:0]       store_word;

   assign accept      = bus.req_valid_i && (state_q == IDLE);
   assign req_aligned = {bus.req_addr_i[ADDR_W-1:2], 2'b00};

   // The range check is done one bit wider so A+3 cannot wrap near the top.
   always_comb begin
      req_err = 1'b0;
      if (bus.req_size_i == 2'b11)
         req_err = 1'b1;
      if (bus.req_size_i == SZ_HALF && bus.req_addr_i[0])
         req_err = 1'b1;
      if (bus.req_size_i == SZ_WORD && bus.req_addr_i[1:0] != 2'b00)
         req_err = 1'b1;
      if (({1'b0, req_aligned} + (ADDR_W+1)'(3)) >= (ADDR_W+1)'(MEM_BYTES))
         req_err = 1'b1;
   end

   lsu_lane_align u_align (
      .word       (mem_rdata_i),
      .addr_lo    (addr_q[1:0]),
      .size       (size_q),
      .sgn        (sgn_q),
      .wdata      (wdata_q),
      .load_val   (load_val),
      .store_word (store_word)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         sgn_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         word_q  <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  write_q <= bus.req_write_i;
                  sgn_q   <= bus.req_signed_i;
                  size_q  <= bus.req_size_i;
                  addr_q  <= bus.req_addr_i;
                  wdata_q <= bus.req_wdata_i;
                  word_q  <= bus.req_wdata_i;
                  err_q   <= req_err;
                  rdata_q <= 32'h0;
                  if (req_err)
                     state_q <= RESP;
                  else if (bus.req_write_i && bus.req_size_i == SZ_WORD)
                     state_q <= WR;
                  else
                     state_q <= RD;
               end
            end
            // A store leaves RD with the merged word; a load with its result.
            RD: begin
               if (write_q) begin
                  word_q  <= store_word;
                  state_q <= WR;
               end else begin
                  rdata_q <= load_val;
                  state_q <= RESP;
               end
            end
            WR:      state_q <= RESP;
            RESP: begin
               if (bus.resp_ready_i)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready_o  = (state_q == IDLE);
   assign bus.resp_valid_o = (state_q == RESP);
   assign bus.resp_rdata_o = (state_q == RESP) ? rdata_q : 32'h0;
   assign bus.resp_err_o   = (state_q == RESP) && err_q;

   assign mem_read_o  = (state_q == RD);
   assign mem_write_o = (state_q == WR);
   assign mem_addr_o  = (state_q == RD || state_q == WR) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem_wdata_o = (state_q == WR) ? word_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory
// model and strobe counters; expected values are hand-computed constants.
module tb_load_store_unit;

   logic        clk_i;
   logic        rst_i;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_write_o;
   logic        mem_read_o;
   logic [31:0] mem_rdata_i;

   lsu_if #(.ADDR_W(32)) bus ();

   load_store_unit #(.MEM_BYTES(32), .ADDR_W(32)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .bus         (bus.slave),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_write_o (mem_write_o),
      .mem_read_o  (mem_read_o),
      .mem_rdata_i (mem_rdata_i)
   );

   logic [31:0] mem [0:7];
   logic        memInit;
   int          rdCount;
   int          wrCount;
   int          bothCount;
   logic [31:0] lastWaddr;
   logic [31:0] lastWdata;
   int          checks;
   int          errors;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   assign mem_rdata_i = mem_read_o ? mem[mem_addr_o[4:2]] : 32'hDEAD_BEEF;

   always @(posedge clk_i) begin
      if (memInit) begin
         for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
         mem[0] <= 32'h5566_7788;
         mem[7] <= 32'hCAFE_F00D;
      end else if (mem_write_o) begin
         mem[mem_addr_o[4:2]] <= mem_wdata_o;
      end
      if (mem_read_o) rdCount++;
      if (mem_write_o) begin
         wrCount++;
         lastWaddr = mem_addr_o;
         lastWdata = mem_wdata_o;
      end
      if (mem_read_o && mem_write_o) bothCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one request, waits for its response, records latency and data.
   task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output int lat, output logic [31:0] rdata, output logic err);
      @(negedge clk_i);
      bus.req_valid_i  = 1'b1;
      bus.req_write_i  = wr;
      bus.req_size_i   = sz;
      bus.req_signed_i = sg;
      bus.req_addr_i   = addr;
      bus.req_wdata_i  = wd;
      @(posedge clk_i);
      #1;
      bus.req_valid_i = 1'b0;
      lat = 1;
      while (!bus.resp_valid_o && lat < 10) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      rdata = bus.resp_rdata_o;
      err   = bus.resp_err_o;
      bus.resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.resp_ready_i = 1'b0;
   endtask

   task automatic runCase(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int expLat, input logic [31:0] expData, input logic expErr,
                          input int expRd, input int expWr);
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          rd0;
      int          wr0;
      rd0 = rdCount;
      wr0 = wrCount;
      applyStimulus(wr, sz, sg, addr, wd, lat, rdata, err);
      checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
      checkOutput({tag, "_rdata"}, rdata, expData);
      checkOutput({tag, "_err"}, {31'h0, err}, {31'h0, expErr});
      checkOutput({tag, "_rdcnt"}, 32'(rdCount - rd0), 32'(expRd));
      checkOutput({tag, "_wrcnt"}, 32'(wrCount - wr0), 32'(expWr));
   endtask

   initial begin
      int          rd0;
      int          wr0;
      int          lat;
      logic [31:0] held;
      checks    = 0;
      errors    = 0;
      rdCount   = 0;
      wrCount   = 0;
      bothCount = 0;
      lastWaddr = 32'h0;
      lastWdata = 32'h0;
      bus.req_valid_i  = 1'b0;
      bus.req_write_i  = 1'b0;
      bus.req_size_i   = 2'b00;
      bus.req_signed_i = 1'b0;
      bus.req_addr_i   = 32'h0;
      bus.req_wdata_i  = 32'h0;
      bus.resp_ready_i = 1'b0;
      memInit = 1'b1;
      rst_i   = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("rst_ready", {31'h0, bus.req_ready_o}, 32'h1);
      checkOutput("rst_valid", {31'h0, bus.resp_valid_o}, 32'h0);
      checkOutput("rst_err", {31'h0, bus.resp_err_o}, 32'h0);
      checkOutput("rst_rdata", bus.resp_rdata_o, 32'h0);
      checkOutput("rst_strobes", {30'h0, mem_read_o, mem_write_o}, 32'h0);
      checkOutput("rst_maddr", mem_addr_o, 32'h0);
      @(negedge clk_i);
      memInit = 1'b0;
      rst_i   = 1'b0;
      rdCount = 0;
      wrCount = 0;

      runCase("st_w8", 1'b1, 2'b10, 1'b0, 32'd8, 32'h1122_3344, 2, 32'h0, 1'b0, 0, 1);
      checkOutput("st_w8_waddr", lastWaddr, 32'd8);
      checkOutput("st_w8_wdata", lastWdata, 32'h1122_3344);
      runCase("ld_w8", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 2, 32'h1122_3344, 1'b0, 1, 0);
      runCase("ld_bu9", 1'b0, 2'b00, 1'b0, 32'd9, 32'h0, 2, 32'h0000_0033, 1'b0, 1, 0);
      runCase("st_b10", 1'b1, 2'b00, 1'b0, 32'd10, 32'hFFFF_FFAB, 3, 32'h0, 1'b0, 1, 1);
      checkOutput("st_b10_waddr", lastWaddr, 32'd8);
      checkOutput("st_b10_wdata", lastWdata, 32'h11AB_3344);
      runCase("ld_bs10", 1'b0, 2'b00, 1'b1, 32'd10, 32'h0, 2, 32'hFFFF_FFAB, 1'b0, 1, 0);
      runCase("ld_hu10", 1'b0, 2'b01, 1'b0, 32'd10, 32'h0, 2, 32'h0000_11AB, 1'b0, 1, 0);
      runCase("ld_hs8", 1'b0, 2'b01, 1'b1, 32'd8, 32'h0, 2, 32'h0000_3344, 1'b0, 1, 0);
      runCase("st_h14", 1'b1, 2'b01, 1'b0, 32'd14, 32'h1234_BEEF, 3, 32'h0, 1'b0, 1, 1);
      checkOutput("st_h14_wdata", lastWdata, 32'hBEEF_0000);
      runCase("ld_hs14", 1'b0, 2'b01, 1'b1, 32'd14, 32'h0, 2, 32'hFFFF_BEEF, 1'b0, 1, 0);
      runCase("ld_w28", 1'b0, 2'b10, 1'b0, 32'd28, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 1, 0);

      runCase("err_w6", 1'b0, 2'b10, 1'b0, 32'd6, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      runCase("err_h5", 1'b1, 2'b01, 1'b0, 32'd5, 32'h55AA, 1, 32'h0, 1'b1, 0, 0);
      runCase("err_sz3", 1'b0, 2'b11, 1'b0, 32'd0, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      runCase("err_w32", 1'b0, 2'b10, 1'b0, 32'd32, 32'h0, 1, 32'h0, 1'b1, 0, 0);

      // Backpressure: response held for 3 cycles while another request waits.
      rd0 = rdCount;
      @(negedge clk_i);
      bus.req_valid_i  = 1'b1;
      bus.req_write_i  = 1'b0;
      bus.req_size_i   = 2'b10;
      bus.req_signed_i = 1'b0;
      bus.req_addr_i   = 32'd8;
      @(posedge clk_i);
      #1;
      bus.req_addr_i = 32'd0;
      lat = 1;
      while (!bus.resp_valid_o && lat < 10) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      checkOutput("bp_lat", 32'(lat), 32'd2);
      held = bus.resp_rdata_o;
      checkOutput("bp_data", held, 32'h11AB_3344);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i);
         #1;
         checkOutput("bp_valid", {31'h0, bus.resp_valid_o}, 32'h1);
         checkOutput("bp_stable", bus.resp_rdata_o, 32'h11AB_3344);
         checkOutput("bp_ready", {31'h0, bus.req_ready_o}, 32'h0);
      end
      bus.req_valid_i  = 1'b0;
      bus.resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.resp_ready_i = 1'b0;
      checkOutput("bp_done_valid", {31'h0, bus.resp_valid_o}, 32'h0);
      checkOutput("bp_done_ready", {31'h0, bus.req_ready_o}, 32'h1);
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("bp_rdcnt", 32'(rdCount - rd0), 32'd1);

      // Reset in the RD cycle of a byte store: no write may happen.
      wr0 = wrCount;
      @(negedge clk_i);
      bus.req_valid_i  = 1'b1;
      bus.req_write_i  = 1'b1;
      bus.req_size_i   = 2'b00;
      bus.req_addr_i   = 32'd0;
      bus.req_wdata_i  = 32'h0000_00EE;
      @(posedge clk_i);
      #1;
      bus.req_valid_i = 1'b0;
      checkOutput("rmw_rd", {31'h0, mem_read_o}, 32'h1);
      #1;
      rst_i = 1'b1;
      #1;
      checkOutput("rmw_rst_strobes", {30'h0, mem_read_o, mem_write_o}, 32'h0);
      checkOutput("rmw_rst_ready", {31'h0, bus.req_ready_o}, 32'h1);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      checkOutput("rmw_post_ready", {31'h0, bus.req_ready_o}, 32'h1);
      checkOutput("rmw_post_valid", {31'h0, bus.resp_valid_o}, 32'h0);
      checkOutput("rmw_wrcnt", 32'(wrCount - wr0), 32'd0);
      runCase("rmw_ld0", 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 2, 32'h5566_7788, 1'b0, 1, 0);

      checkOutput("no_overlap", 32'(bothCount), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
